// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared constants for the immediate-extension stage.
//   MODE_W             width of the extension-mode field
//   MODE_SIGN/ZERO/UPPER/BRANCH  extension mode encodings
//   state_t            handshake buffer FSM states (ST_EMPTY/ST_HALF/ST_FULL)
package imm_ext_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_SIGN   = 2'b00;
    localparam logic [MODE_W-1:0] MODE_ZERO   = 2'b01;
    localparam logic [MODE_W-1:0] MODE_UPPER  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension mux.
// Ports:
//   Imm_In   [IN_WIDTH-1:0]   raw immediate
//   Mode_In  [MODE_W-1:0]     extension mode (SIGN/ZERO/UPPER/BRANCH)
//   ext_value[OUT_WIDTH-1:0]  extended operand
// Requires OUT_WIDTH >= IN_WIDTH + 2.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  Imm_In,
    input  logic [MODE_W-1:0]    Mode_In,
    output logic [OUT_WIDTH-1:0] ext_value
);

    localparam int unsigned PAD_W = OUT_WIDTH - IN_WIDTH;

    logic [OUT_WIDTH-1:0] sign_ext;

    // Mode mux; BRANCH is the sign extension scaled to a word offset.
    always_comb begin
        sign_ext  = {{PAD_W{Imm_In[IN_WIDTH-1]}}, Imm_In};
        ext_value = sign_ext;
        case (Mode_In)
            MODE_SIGN:   ext_value = sign_ext;
            MODE_ZERO:   ext_value = {{PAD_W{1'b0}}, Imm_In};
            MODE_UPPER:  ext_value = {Imm_In, {PAD_W{1'b0}}};
            MODE_BRANCH: ext_value = {sign_ext[OUT_WIDTH-3:0], 2'b00};
            default:     ext_value = sign_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// imm_extend_unit: registered immediate-extension stage with valid/ready.
// Ports:
//   CLK, RST (async active-low), Flush (sync, empties the unit)
//   In_Valid/In_Ready, Imm_In[IN_WIDTH-1:0], Mode_In[1:0]   input side
//   Out_Valid/Out_Ready, Imm_Out[OUT_WIDTH-1:0]             output side
// Build option: IMM_EXT_SKID_EN defined -> two-entry skid buffer, In_Ready
// registered; undefined -> single register, In_Ready = !Out_Valid || Out_Ready.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Flush,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [IN_WIDTH-1:0]  Imm_In,
    input  logic [MODE_W-1:0]    Mode_In,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [OUT_WIDTH-1:0] Imm_Out
);

    state_t               state_q;
    state_t               state_d;
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic                 in_fire;
    logic                 out_fire;
    logic                 load_main_ext;
    logic [OUT_WIDTH-1:0] ext_value;
    logic [OUT_WIDTH-1:0] main_q;

    imm_ext_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .Imm_In    (Imm_In),
        .Mode_In   (Mode_In),
        .ext_value (ext_value)
    );

`ifdef IMM_EXT_SKID_EN
    logic                 in_ready_q;
    logic                 in_ready_d;
    logic                 load_main_skid;
    logic                 load_skid;
    logic [OUT_WIDTH-1:0] skid_q;

    assign In_Ready = in_ready_q;
`else
    // Single register: a full stage can accept only if it drains this cycle.
    assign In_Ready = !out_valid_q || Out_Ready;
`endif

    assign Out_Valid = out_valid_q;
    assign Imm_Out   = main_q;
    assign in_fire   = In_Valid && In_Ready;
    assign out_fire  = out_valid_q && Out_Ready;

    // State register, plus handshake outputs registered from next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
`ifdef IMM_EXT_SKID_EN
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
`ifdef IMM_EXT_SKID_EN
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    // Next-state and datapath load decode; Flush overrides every fire.
    always_comb begin
        state_d        = state_q;
        load_main_ext  = 1'b0;
`ifdef IMM_EXT_SKID_EN
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
`endif
        if (Flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d       = ST_HALF;
                        load_main_ext = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        load_main_ext = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
`ifdef IMM_EXT_SKID_EN
                    end else if (in_fire) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
`endif
                    end
                end
`ifdef IMM_EXT_SKID_EN
                ST_FULL: begin
                    if (out_fire) begin
                        state_d        = ST_HALF;
                        load_main_skid = 1'b1;
                    end
                end
`endif
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output decode from next state so the handshake flags come straight off flops.
    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
`ifdef IMM_EXT_SKID_EN
        in_ready_d  = (state_d != ST_FULL);
`endif
    end

    // Operand registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            main_q <= '0;
`ifdef IMM_EXT_SKID_EN
            skid_q <= '0;
`endif
        end else begin
`ifdef IMM_EXT_SKID_EN
            if (load_main_ext) begin
                main_q <= ext_value;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= ext_value;
            end
`else
            if (load_main_ext) begin
                main_q <= ext_value;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: directed self-checking bench for imm_extend_unit.
// Instance a: IN=16/OUT=32; instance b: IN=8/OUT=16.
module tb_imm_extend_unit;
    import imm_ext_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm_in;
    logic [1:0]  mode_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_imm_in;
    logic [1:0]  b_mode_in;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_imm_out;

    int vectors;
    int miscompares;

    imm_extend_unit #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut_a (
        .CLK(clk), .RST(rst), .Flush(flush),
        .In_Valid(in_valid), .In_Ready(in_ready),
        .Imm_In(imm_in), .Mode_In(mode_in),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Imm_Out(imm_out)
    );

    imm_extend_unit #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut_b (
        .CLK(clk), .RST(rst), .Flush(1'b0),
        .In_Valid(b_in_valid), .In_Ready(b_in_ready),
        .Imm_In(b_imm_in), .Mode_In(b_mode_in),
        .Out_Valid(b_out_valid), .Out_Ready(b_out_ready), .Imm_Out(b_imm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; imm_in = '0; mode_in = MODE_SIGN; out_ready = 1'b1;
        b_in_valid = 1'b0; b_imm_in = '0; b_mode_in = MODE_SIGN; b_out_ready = 1'b1;
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (imm_out !== 32'h0) begin miscompares++; $display("FAIL reset_imm_out got %h want 0", imm_out); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_modes();
        logic [15:0] v_imm [4];
        logic [1:0]  v_mode [4];
        logic [31:0] v_exp [4];
        v_imm[0] = 16'h803D; v_mode[0] = MODE_SIGN;   v_exp[0] = 32'hFFFF803D;
        v_imm[1] = 16'h803D; v_mode[1] = MODE_ZERO;   v_exp[1] = 32'h0000803D;
        v_imm[2] = 16'h1234; v_mode[2] = MODE_UPPER;  v_exp[2] = 32'h12340000;
        v_imm[3] = 16'hFFFF; v_mode[3] = MODE_BRANCH; v_exp[3] = 32'hFFFFFFFC;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; imm_in = v_imm[i]; mode_in = v_mode[i];
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mode%0d_in_ready got %b want 1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mode%0d_out_valid got %b want 1", i, out_valid); end
            vectors++; if (imm_out !== v_exp[i]) begin miscompares++; $display("FAIL mode%0d_imm_out got %h want %h", i, imm_out, v_exp[i]); end
            tick();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mode%0d_drain got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s_imm [8];
        logic [31:0] s_exp [8];
        s_imm[0] = 16'h0001; s_exp[0] = 32'h00000001;
        s_imm[1] = 16'h7FFF; s_exp[1] = 32'h00007FFF;
        s_imm[2] = 16'h8000; s_exp[2] = 32'hFFFF8000;
        s_imm[3] = 16'hFFFF; s_exp[3] = 32'hFFFFFFFF;
        s_imm[4] = 16'h1234; s_exp[4] = 32'h00001234;
        s_imm[5] = 16'hABCD; s_exp[5] = 32'hFFFFABCD;
        s_imm[6] = 16'h4000; s_exp[6] = 32'h00004000;
        s_imm[7] = 16'hC000; s_exp[7] = 32'hFFFFC000;
        out_ready = 1'b1; mode_in = MODE_SIGN;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; imm_in = s_imm[i];
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream%0d_in_ready got %b want 1", i, in_ready); end
            tick();
            vectors++; if (out_valid !== 1'b1 || imm_out !== s_exp[i]) begin miscompares++; $display("FAIL stream%0d got v=%b %h want v=1 %h", i, out_valid, imm_out, s_exp[i]); end
        end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; mode_in = MODE_SIGN;
        in_valid = 1'b1; imm_in = 16'h0001;
        tick();
        vectors++; if (out_valid !== 1'b1 || imm_out !== 32'h1) begin miscompares++; $display("FAIL bp_first got v=%b %h want v=1 1", out_valid, imm_out); end
`ifdef IMM_EXT_SKID_EN
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_half_ready got %b want 1", in_ready); end
        imm_in = 16'h0002;
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        vectors++; if (imm_out !== 32'h1) begin miscompares++; $display("FAIL bp_hold1 got %h want 1", imm_out); end
        imm_in = 16'h0003;
        tick();
        vectors++; if (in_ready !== 1'b0 || imm_out !== 32'h1) begin miscompares++; $display("FAIL bp_hold2 got r=%b %h want r=0 1", in_ready, imm_out); end
        out_ready = 1'b1;
        tick();
        vectors++; if (imm_out !== 32'h2 || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_out2 got r=%b %h want r=1 2", in_ready, imm_out); end
        tick();
`else
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_low got %b want 0", in_ready); end
        imm_in = 16'h0002;
        tick();
        vectors++; if (imm_out !== 32'h1) begin miscompares++; $display("FAIL bp_hold1 got %h want 1", imm_out); end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_comb got %b want 1", in_ready); end
        tick();
        vectors++; if (imm_out !== 32'h2) begin miscompares++; $display("FAIL bp_out2 got %h want 2", imm_out); end
        imm_in = 16'h0003;
        tick();
`endif
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || imm_out !== 32'h3) begin miscompares++; $display("FAIL bp_out3 got v=%b %h want v=1 3", out_valid, imm_out); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; mode_in = MODE_ZERO;
        in_valid = 1'b1; imm_in = 16'hAAAA;
        tick();
`ifdef IMM_EXT_SKID_EN
        imm_in = 16'hBBBB;
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_full_ready got %b want 0", in_ready); end
`endif
        flush = 1'b1; out_ready = 1'b1; imm_in = 16'hCCCC;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stale got %b want 0", out_valid); end
        in_valid = 1'b1; imm_in = 16'h00DD;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || imm_out !== 32'h000000DD) begin miscompares++; $display("FAIL flush_resume got v=%b %h want v=1 000000dd", out_valid, imm_out); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_drain got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; mode_in = MODE_SIGN;
        in_valid = 1'b1; imm_in = 16'h8123;
        tick();
        vectors++; if (out_valid !== 1'b1 || imm_out !== 32'hFFFF8123) begin miscompares++; $display("FAIL ar_pre got v=%b %h want v=1 ffff8123", out_valid, imm_out); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_out_valid got %b want 0", out_valid); end
        vectors++; if (imm_out !== 32'h0) begin miscompares++; $display("FAIL ar_imm_out got %h want 0", imm_out); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ar_in_ready got %b want 1", in_ready); end
        mode_in = MODE_ZERO; imm_in = 16'h00FF; out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_held got %b want 0", out_valid); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || imm_out !== 32'h000000FF) begin miscompares++; $display("FAIL ar_resume got v=%b %h want v=1 000000ff", out_valid, imm_out); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_drain got %b want 0", out_valid); end
    endtask

    task automatic test_sweep();
        logic [7:0]  w_imm [4];
        logic [1:0]  w_mode [4];
        logic [15:0] w_exp [4];
        w_imm[0] = 8'h80; w_mode[0] = MODE_SIGN;   w_exp[0] = 16'hFF80;
        w_imm[1] = 8'h80; w_mode[1] = MODE_BRANCH; w_exp[1] = 16'hFE00;
        w_imm[2] = 8'h80; w_mode[2] = MODE_ZERO;   w_exp[2] = 16'h0080;
        w_imm[3] = 8'h5A; w_mode[3] = MODE_UPPER;  w_exp[3] = 16'h5A00;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1; b_imm_in = w_imm[i]; b_mode_in = w_mode[i];
            tick();
            b_in_valid = 1'b0;
            vectors++; if (b_out_valid !== 1'b1 || b_imm_out !== w_exp[i]) begin miscompares++; $display("FAIL sweep%0d got v=%b %h want v=1 %h", i, b_out_valid, b_imm_out, w_exp[i]); end
            tick();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
